// File: rtl/edge_frame_buffer.sv
// Bitmap frame buffer: raster-order 1-bit edge pixels in, beam-addressed pixel out.
// Read path has a fixed 2-cycle latency so the VGA stage can align it with a delayed display-enable.
module edge_frame_buffer #(
  parameter int IMG_W = 200,
  parameter int IMG_H = 200,
  parameter int X_OFF = 0,
  parameter int Y_OFF = 0,
  parameter bit BG    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_start,
  input  logic       wr_valid,
  input  logic       wr_pixel,
  output logic       wr_ready,
  output logic       frame_valid,
  input  logic [9:0] rd_x,
  input  logic [9:0] rd_y,
  input  logic       rd_de,
  output logic       pix_out,
  output logic       pix_de
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} wr_state_t;

  wr_state_t   wr_state;
  logic [15:0] wr_addr;
  logic        accept;
  logic        mem [DEPTH];
  logic        mem_q;

  int          x_rel;
  int          y_rel;
  logic        in_win;
  logic [15:0] rd_addr;
  logic        in_win_d;
  logic        de_d;

  assign accept = wr_valid && wr_ready;

  // wr_ready is a registered copy of "in LOAD"; wr_start outside IDLE/DONE is ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state    <= IDLE;
      wr_addr     <= '0;
      wr_ready    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      case (wr_state)
        IDLE, DONE: begin
          if (wr_start) begin
            wr_state <= LOAD;
            wr_ready <= 1'b1;
            wr_addr  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (wr_addr == LAST_ADDR) begin
              wr_state    <= DONE;
              wr_ready    <= 1'b0;
              frame_valid <= 1'b1;
              wr_addr     <= '0;
            end else begin
              wr_addr <= wr_addr + 16'd1;
            end
          end
        end
        default: begin
          wr_state <= IDLE;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

  // Synchronous-read RAM; a same-address write in the same cycle is seen only on the next read.
  always_ff @(posedge clk) begin
    if (accept && reset_n)
      mem[wr_addr] <= wr_pixel;
    mem_q <= mem[rd_addr];
  end

  always_comb begin
    x_rel   = int'(rd_x) - X_OFF;
    y_rel   = int'(rd_y) - Y_OFF;
    in_win  = rd_de && (x_rel >= 0) && (x_rel < IMG_W) && (y_rel >= 0) && (y_rel < IMG_H);
    rd_addr = 16'(y_rel * IMG_W + x_rel);
  end

  // Stage 1 delays window/enable alongside the RAM read; stage 2 selects the displayed value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_win_d <= 1'b0;
      de_d     <= 1'b0;
      pix_out  <= 1'b0;
      pix_de   <= 1'b0;
    end else begin
      in_win_d <= in_win;
      de_d     <= rd_de;
      pix_de   <= de_d;
      pix_out  <= !de_d ? 1'b0 : !in_win_d ? BG : !frame_valid ? 1'b0 : mem_q;
    end
  end

endmodule
